// File: rtl/hack_pkg.sv
// hack_pkg
//   Shared constants and types for the Hack data-memory slice.
//   - DW / AW        : cpu data word width and data address width
//   - ADDR_*         : memory-mapped I/O word addresses
//   - region_e       : which target an address selects
//   - decode_region  : address -> region_e, RAM window given by its width
package hack_pkg;

    localparam int DW = 16;
    localparam int AW = 15;

    localparam logic [AW-1:0] ADDR_SW  = 15'h6000;
    localparam logic [AW-1:0] ADDR_LED = 15'h6001;
    localparam logic [AW-1:0] ADDR_MS  = 15'h6002;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SW,
        REG_LED,
        REG_MS,
        REG_NONE
    } region_e;

    // RAM occupies the bottom 2**ram_aw words; everything above the RAM
    // window that is not one of the I/O registers reads as zero.
    function automatic region_e decode_region(input logic [AW-1:0] addr,
                                              input int ram_aw);
        region_e r;
        if ((addr >> ram_aw) == '0)  r = REG_RAM;
        else if (addr == ADDR_SW)    r = REG_SW;
        else if (addr == ADDR_LED)   r = REG_LED;
        else if (addr == ADDR_MS)    r = REG_MS;
        else                         r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/hack_data_mem_sw_debounce.sv
// sw_debounce
//   Brings asynchronous board switches into the clock domain and only
//   accepts a new value once it has been stable for DEB_CYCLES cycles.
//   Ports:
//     clk       in  1  clock
//     rst       in  1  synchronous reset, active-high
//     sw_in     in  W  asynchronous switch inputs
//     sw_stable out W  debounced switch value
module sw_debounce #(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw_in,
    output logic [W-1:0] sw_stable
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [W-1:0]  sync_p0;
    logic [W-1:0]  sw_sync;
    logic [CW-1:0] deb_cnt;

    // Two-flop synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sw_sync <= '0;
        end else begin
            sync_p0 <= sw_in;
            sw_sync <= sync_p0;
        end
    end

    // Debounce: any return to the accepted value restarts the wait, so
    // short glitches never reach sw_stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt   <= '0;
            sw_stable <= '0;
        end else if (sw_sync == sw_stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
            sw_stable <= sw_sync;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hack_data_mem.sv
// hack_data_mem
//   Data memory and memory-mapped I/O slave for the Hack cpu.
//   Map: 0x0000-0x3FFF RAM, 0x6000 switches (RO), 0x6001 LED (RW),
//        0x6002 millisecond counter (read value, write clears), others read 0.
//   Ports:
//     clk50m   in  1      50 MHz clock
//     rst      in  1      synchronous reset, active-high
//     en25m    in  1      cpu step enable, qualifies writes
//     writeM   in  1      cpu write request
//     outM     in  DW     cpu write data
//     addressM in  AW     cpu data address
//     inM      out DW     registered read data (1 cycle latency)
//     sw_in    in  SW_W   asynchronous switches
//     led      out LED_W  LED register
module hack_data_mem
    import hack_pkg::*;
#(
    parameter int DW         = hack_pkg::DW,
    parameter int AW         = hack_pkg::AW,
    parameter int RAM_AW     = 14,
    parameter int SW_W       = 4,
    parameter int LED_W      = 8,
    parameter int DEB_CYCLES = 500000,
    parameter int TICK_DIV   = 50000
) (
    input  logic             clk50m,
    input  logic             rst,
    input  logic             en25m,
    input  logic             writeM,
    input  logic [DW-1:0]    outM,
    input  logic [AW-1:0]    addressM,
    output logic [DW-1:0]    inM,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led
);

    localparam int RAM_DEPTH = 2 ** RAM_AW;
    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0]     ram [RAM_DEPTH];
    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_en;
    logic [SW_W-1:0]   sw_stable;
    logic [PW-1:0]     prescaler;
    logic [DW-1:0]     ms;
    logic              tick;

    always_comb begin
        region  = decode_region(addressM, RAM_AW);
        ram_idx = addressM[RAM_AW-1:0];
        wr_en   = en25m & writeM;
        tick    = (prescaler == PW'(TICK_DIV - 1));
    end

    sw_debounce #(
        .W          (SW_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_debounce (
        .clk       (clk50m),
        .rst       (rst),
        .sw_in     (sw_in),
        .sw_stable (sw_stable)
    );

    // RAM write port; contents survive reset
    always_ff @(posedge clk50m) begin
        if (wr_en && region == REG_RAM)
            ram[ram_idx] <= outM;
    end

    always_ff @(posedge clk50m) begin
        if (rst)
            led <= '0;
        else if (wr_en && region == REG_LED)
            led <= outM[LED_W-1:0];
    end

    // Millisecond timer; a clear write beats a coincident tick
    always_ff @(posedge clk50m) begin
        if (rst) begin
            prescaler <= '0;
            ms        <= '0;
        end else if (wr_en && region == REG_MS) begin
            prescaler <= '0;
            ms        <= '0;
        end else if (tick) begin
            prescaler <= '0;
            ms        <= ms + DW'(1);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Read register: samples pre-edge state, so a same-cycle write
    // shows the old value here and the new one a cycle later.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            inM <= '0;
        end else begin
            case (region)
                REG_RAM: inM <= ram[ram_idx];
                REG_SW:  inM <= DW'(sw_stable);
                REG_LED: inM <= DW'(led);
                REG_MS:  inM <= ms;
                default: inM <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_data_mem.sv
module tb_hack_data_mem;

    logic        clk50m = 1'b0;
    logic        rst;
    logic        en25m;
    logic        writeM;
    logic [15:0] outM;
    logic [14:0] addressM;
    logic [15:0] inM;
    logic [3:0]  sw_in;
    logic [7:0]  led;

    typedef struct {
        bit          is_led;
        logic [15:0] lo;
        logic [15:0] hi;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   chk_fire = 1'b0;
    bit   chk_vld  = 1'b0;
    int   total    = 0;
    int   bad      = 0;
    logic [15:0] act;

    hack_data_mem #(
        .DW         (16),
        .AW         (15),
        .RAM_AW     (14),
        .SW_W       (4),
        .LED_W      (8),
        .DEB_CYCLES (4),
        .TICK_DIV   (5)
    ) dut (
        .clk50m   (clk50m),
        .rst      (rst),
        .en25m    (en25m),
        .writeM   (writeM),
        .outM     (outM),
        .addressM (addressM),
        .inM      (inM),
        .sw_in    (sw_in),
        .led      (led)
    );

    always #5 clk50m = ~clk50m;

    // A check issued for a cycle becomes due one edge later
    always @(posedge clk50m) chk_vld <= chk_fire;

    // Monitor: pops the expected value whenever a response is due
    always @(negedge clk50m) begin
        if (chk_vld) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL no_expectation: response due but scoreboard empty");
            end else begin
                e   = sb.pop_front();
                act = e.is_led ? {8'h00, led} : inM;
                if (act < e.lo || act > e.hi) begin
                    bad = bad + 1;
                    $display("FAIL %s: got 0x%04h expected 0x%04h..0x%04h",
                             e.name, act, e.lo, e.hi);
                end
            end
        end
    end

    task automatic cyc(input logic [14:0] a, input logic w, input logic en,
                       input logic [15:0] d, input bit chk, input bit is_led,
                       input logic [15:0] lo, input logic [15:0] hi,
                       input string nm);
        exp_t x;
        addressM = a;
        writeM   = w;
        en25m    = en;
        outM     = d;
        chk_fire = chk;
        if (chk) begin
            x.is_led = is_led;
            x.lo     = lo;
            x.hi     = hi;
            x.name   = nm;
            sb.push_back(x);
        end
        @(negedge clk50m);
    endtask

    task automatic rd(input logic [14:0] a, input logic [15:0] ex, input string nm);
        cyc(a, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, ex, ex, nm);
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        cyc(a, 1'b1, 1'b1, d, 1'b0, 1'b0, 16'h0, 16'h0, "");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(15'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, "");
    endtask

    initial begin
        rst      = 1'b1;
        en25m    = 1'b0;
        writeM   = 1'b0;
        outM     = 16'h0;
        addressM = 15'h0;
        sw_in    = 4'h0;
        @(negedge clk50m);

        // Reset: two cycles
        rd(15'h6001, 16'h0000, "rst_inM");
        cyc(15'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0, 16'h0, "rst_led");
        rst = 1'b0;

        // Timer: ticks land on edges 5,10,..,25 after reset release
        cyc(15'h6002, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h1, "ms_post_rst");
        idle(24);
        rd(15'h6002, 16'd5, "ms_after_25");
        idle(3);
        // Edge 30 carries both a tick and the clear; read shows old value
        cyc(15'h6002, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'd5, 16'd5, "ms_old_on_clear");
        rd(15'h6002, 16'd0, "ms_cleared");
        idle(3);
        rd(15'h6002, 16'd0, "ms_pre_tick");
        rd(15'h6002, 16'd1, "ms_tick_after_clear");

        // RAM
        wr(15'h0005, 16'h1234);
        rd(15'h0005, 16'h1234, "ram_5");
        cyc(15'h0005, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0, "");
        rd(15'h0005, 16'h1234, "ram_no_en");
        wr(15'h3FFF, 16'hBEEF);
        rd(15'h3FFF, 16'hBEEF, "ram_top");

        // LED and unmapped
        cyc(15'h6001, 1'b1, 1'b1, 16'hFFA5, 1'b1, 1'b1, 16'h00A5, 16'h00A5, "led_write");
        rd(15'h6001, 16'h00A5, "led_read");
        cyc(15'h6001, 1'b1, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h00A5, 16'h00A5, "led_no_en");
        wr(15'h4000, 16'hDEAD);
        rd(15'h4000, 16'h0000, "unmapped_4000");
        wr(15'h4005, 16'hDEAD);
        rd(15'h0005, 16'h1234, "ram_no_alias");
        wr(15'h6000, 16'hFFFF);
        rd(15'h6000, 16'h0000, "sw_write_ignored");

        // Debounce: new value accepted on the 6th edge, visible on the 7th read
        sw_in = 4'b1010;
        for (int i = 0; i < 7; i++)
            rd(15'h6000, (i < 6) ? 16'h0000 : 16'h000A, "sw_debounce");

        // Two-cycle glitch must be rejected
        sw_in = 4'b0001;
        rd(15'h6000, 16'h000A, "sw_glitch");
        rd(15'h6000, 16'h000A, "sw_glitch");
        sw_in = 4'b1010;
        for (int i = 0; i < 8; i++)
            rd(15'h6000, 16'h000A, "sw_glitch");

        // Read-during-write returns old data
        wr(15'h0007, 16'h0001);
        cyc(15'h0007, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0001, 16'h0001, "rdw_old");
        rd(15'h0007, 16'h0002, "rdw_new");

        // Reset mid-sequence: registers clear, RAM keeps its contents
        wr(15'h6001, 16'h003C);
        cyc(15'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h003C, 16'h003C, "led_before_rst");
        rst = 1'b1;
        cyc(15'h0007, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0, 16'h0, "rst2_led");
        rst = 1'b0;
        rd(15'h6002, 16'h0000, "rst2_ms");
        rd(15'h0007, 16'h0002, "rst2_ram_kept");
        rd(15'h6000, 16'h0000, "rst2_sw");
        idle(2);

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clk50m);
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
